// File: rtl/stmt_lowerer_seq_dispatch.sv
// Sequential command dispatcher: range-decodes an opcode into one of four lanes, holds the command
// lane*HOLD_SCALE cycles, then issues it downstream. STMT_LOWERER_SEQ_STATS_EN adds err_count.
module stmt_lowerer_seq_dispatch #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned HOLD_SCALE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_lane,
  output logic [DATA_W-1:0] out_data,
  output logic              err_pulse,
`ifdef STMT_LOWERER_SEQ_STATS_EN
  output logic [15:0]       err_count,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StHold, StIssue} state_e;

  localparam logic [2:0] Scale = 3'(HOLD_SCALE);

  state_e            state_q;
  logic [4:0]        hold_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              err_q;

  logic              dec_match;
  logic [1:0]        dec_lane;
  logic [4:0]        hold_calc;
  logic              accept;
  logic              drop;

  // First match wins; the top-bit wildcard only applies once the explicit ranges miss.
  always_comb begin
    dec_match = 1'b1;
    dec_lane  = 2'd0;
    case (in_op) inside
      8'h00:          dec_lane = 2'd0;
      [8'h10:8'h1F]:  dec_lane = 2'd1;
      [8'h20:8'h23]:  dec_lane = 2'd2;
      default: begin
        casez (in_op)
          8'b1???????: dec_lane  = 2'd3;
          default:     dec_match = 1'b0;
        endcase
      end
    endcase
  end

  // Scaled hold length selected from a bounded sweep over every 3-bit lane index.
  always_comb begin
    hold_calc = 5'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (3'(i) == {1'b0, dec_lane}) hold_calc = 5'(i) * 5'(Scale);
    end
  end

  assign in_ready  = rst_n && (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign drop      = accept && !dec_match;
  assign out_valid = valid_q;
  assign out_lane  = lane_q;
  assign out_data  = data_q;
  assign err_pulse = err_q;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= 5'd0;
      lane_q  <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= drop;
      case (state_q)
        StIdle: begin
          if (accept && dec_match) begin
            lane_q <= dec_lane;
            data_q <= in_data;
            if (hold_calc == 5'd0) begin
              state_q <= StIssue;
              valid_q <= 1'b1;
            end else begin
              hold_q  <= hold_calc;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          hold_q <= hold_q - 5'd1;
          if (hold_q == 5'd1) begin
            state_q <= StIssue;
            valid_q <= 1'b1;
          end
        end
        StIssue: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef STMT_LOWERER_SEQ_STATS_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else if (drop && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_stmt_lowerer_seq_dispatch.sv
// Directed bench for stmt_lowerer_seq_dispatch: a scoreboard queue holds expected lane/payload per
// accepted command and is checked at each downstream handshake.
module tb_stmt_lowerer_seq_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_op;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_lane;
  logic [7:0] out_data;
  logic       err_pulse;
  logic       busy;
`ifdef STMT_LOWERER_SEQ_STATS_EN
  logic [15:0] err_count;
`endif

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_xfer = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  stmt_lowerer_seq_dispatch #(
    .DATA_W    (8),
    .HOLD_SCALE(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lane (out_lane),
    .out_data (out_data),
    .err_pulse(err_pulse),
`ifdef STMT_LOWERER_SEQ_STATS_EN
    .err_count(err_count),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void ref_decode(input logic [7:0] op, output logic m, output logic [1:0] l);
    m = 1'b1;
    l = 2'd0;
    if (op == 8'h00) l = 2'd0;
    else if (op >= 8'h10 && op <= 8'h1F) l = 2'd1;
    else if (op >= 8'h20 && op <= 8'h23) l = 2'd2;
    else if (op[7]) l = 2'd3;
    else m = 1'b0;
  endfunction

  // One clock: predicts accepts/handshakes from pre-edge signals, checks them after the edge.
  task automatic tick();
    logic       hs, acc, m, exp_err, rst_at;
    logic [1:0] l;
    exp_t       e;
    logic [1:0] cap_l;
    logic [7:0] cap_d;
    hs     = out_valid && out_ready && rst_n;
    acc    = in_valid && in_ready;
    rst_at = rst_n;
    cap_l  = out_lane;
    cap_d  = out_data;
    ref_decode(in_op, m, l);
    if (acc && m) sb_q.push_back({l, in_data});
    exp_err = acc && !m;
    @(posedge clk);
    #1;
    if (!rst_at) sb_q.delete();
    if (hs) begin
      n_xfer++;
      chk("sb_nonempty", (sb_q.size() != 0), 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_lane", cap_l, e.lane);
        chk("sb_data", cap_d, e.data);
      end
    end
    chk("err_pulse", err_pulse, exp_err);
  endtask

  task automatic send(input logic [7:0] op, input logic [7:0] d, input int exp_lat,
                      input string tag);
    int lat;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("busy_hold", busy, 1'b1);
      tick();
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic drain(input logic [1:0] lane, input logic [7:0] d);
    tick();
    chk("in_ready_after", in_ready, 1'b1);
    chk("out_valid_after", out_valid, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("lane_retained", out_lane, lane);
    chk("data_retained", out_data, d);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_op     = 8'h00;
    in_data   = 8'h11;
    out_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    chk("rst_lane", out_lane, 2'd0);
    chk("rst_data", out_data, 8'h00);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);
`ifdef STMT_LOWERER_SEQ_STATS_EN
    chk("cnt_reset", err_count, 16'd0);
`endif

    // Lane latencies with HOLD_SCALE=1, including range edges.
    send(8'h00, 8'hA5, 1, "lat_lane0");
    chk("l0_lane", out_lane, 2'd0);
    chk("l0_data", out_data, 8'hA5);
    drain(2'd0, 8'hA5);
    send(8'h1F, 8'h3B, 2, "lat_lane1");
    drain(2'd1, 8'h3B);
    send(8'h10, 8'h4C, 2, "lat_lane1_lo");
    drain(2'd1, 8'h4C);
    send(8'h22, 8'h96, 3, "lat_lane2");
    drain(2'd2, 8'h96);
    send(8'h23, 8'h01, 3, "lat_lane2_hi");
    drain(2'd2, 8'h01);
    send(8'hC3, 8'hE7, 4, "lat_lane3");
    drain(2'd3, 8'hE7);
    send(8'h80, 8'h5E, 4, "lat_lane3_lo");
    drain(2'd3, 8'h5E);

    // Backpressure: a pending upstream command must stay blocked while ISSUE stalls.
    out_ready = 1'b0;
    send(8'hFF, 8'h5A, 4, "lat_bp");
    in_valid = 1'b1;
    in_op    = 8'h11;
    in_data  = 8'hEE;
    n_xfer   = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_lane", out_lane, 2'd3);
      chk("bp_data", out_data, 8'h5A);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(2'd3, 8'h5A);
    chk("bp_one_xfer", n_xfer, 1);

    // Unmatched drops, back to back, around each range boundary.
    in_valid = 1'b1;
    in_op    = 8'h30;
    in_data  = 8'h99;
    tick();
    chk("drop_no_valid", out_valid, 1'b0);
    chk("drop_in_ready", in_ready, 1'b1);
`ifdef STMT_LOWERER_SEQ_STATS_EN
    chk("cnt_one", err_count, 16'd1);
`endif
    in_op = 8'h24;
    tick();
    in_op = 8'h0F;
    tick();
    in_op = 8'h7F;
    tick();
    in_valid = 1'b0;
    tick();
    chk("drop_none_out", out_valid, 1'b0);
    chk("drop_lane_kept", out_lane, 2'd3);
`ifdef STMT_LOWERER_SEQ_STATS_EN
    chk("cnt_four", err_count, 16'd4);
`endif

    // Reset while a lane 2 command is still holding.
    in_valid = 1'b1;
    in_op    = 8'h21;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    tick();
    chk("mid_still_hold", out_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_busy_clr", busy, 1'b0);
    chk("mid_lane", out_lane, 2'd0);
    chk("mid_data", out_data, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("mid_in_ready", in_ready, 1'b1);
    chk("mid_no_issue", out_valid, 1'b0);
`ifdef STMT_LOWERER_SEQ_STATS_EN
    chk("cnt_cleared", err_count, 16'd0);
`endif
    send(8'h00, 8'h77, 1, "lat_post_rst");
    drain(2'd0, 8'h77);

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stmt_lowerer_seq_dispatch.md
Name: stmt_lowerer_seq_dispatch

Overview:
- Sequential command dispatcher. Accepts an 8-bit opcode plus payload over a valid/ready handshake.
- Classifies the opcode into one of 4 lanes by priority range-match decode (case inside style).
- Holds each command for a lane-dependent number of cycles, then issues it downstream over a second valid/ready handshake.
- Sits directly downstream of the combinational select/decode fixtures and consumes their select/opcode-style inputs.
- Exercises always_ff lowering of case inside, casez, bounded for loops and FSM state registers.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- HOLD_SCALE, 1, hold cycles per lane index (0..7). Hold length = lane * HOLD_SCALE.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream command valid.
- in_ready  output  1  upstream ready.
- in_op  input  8  opcode.
- in_data  input  DATA_W  payload.
- out_valid  output  1  downstream command valid.
- out_ready  input  1  downstream ready.
- out_lane  output  2  decoded lane of the issued command.
- out_data  output  DATA_W  payload of the issued command.
- err_pulse  output  1  one-cycle pulse when an unmatched opcode is dropped.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at posedge clk.
- Reset values: state=IDLE; out_valid=0, out_lane=0, out_data=0, err_pulse=0, busy=0.
- in_ready = rst_n && (state==IDLE). It is 0 while rst_n is low.
- Decode, first match wins, evaluated on in_op at accept:
  - 8'h00 -> lane 0.
  - [8'h10:8'h1F] -> lane 1.
  - [8'h20:8'h23] -> lane 2.
  - casez 8'b1??????? (8'h80-8'hFF) -> lane 3.
  - anything else -> no match.
- FSM states: IDLE, HOLD, ISSUE.
- IDLE: accept fires when in_valid && in_ready.
  - No match: remain IDLE; err_pulse=1 for exactly the next cycle; payload discarded.
  - Match: latch lane and in_data; hold_cnt = lane*HOLD_SCALE (3-bit lane times 3-bit scale, 5-bit result, no overflow).
  - hold_cnt==0 -> ISSUE; otherwise -> HOLD.
- HOLD: hold_cnt decrements by 1 each cycle. When hold_cnt==1, go to ISSUE next cycle.
- ISSUE: out_valid=1; out_lane/out_data stay stable until the handshake.
  - On out_valid && out_ready: go to IDLE; out_valid=0 the next cycle.
  - out_ready low holds ISSUE indefinitely, with no data change.
- Latency: accept at cycle T -> out_valid first high at T+1+lane*HOLD_SCALE.
- Minimum spacing between accepts: 2+lane*HOLD_SCALE cycles. in_ready rises the cycle after the downstream handshake. No skid/bypass.
- out_lane and out_data are registered and updated only on a matched accept; they retain their value in IDLE.
- Simultaneous events: in_valid during HOLD/ISSUE is ignored (in_ready=0); upstream must hold its command.
- Reset mid-HOLD or mid-ISSUE: the command is dropped, all outputs return to reset values the next cycle, and no err_pulse is generated.
- The hold counter is a bounded loop: it is implemented with a for loop over 0..7 lanes computing the scaled hold. No unbounded loops.

Optional Feature:
- Macro: STMT_LOWERER_SEQ_STATS_EN.
- Defined: adds output port err_count [15:0].
  - Increments by 1 on each unmatched-opcode drop (same cycle err_pulse asserts).
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with in_valid=1, in_op=8'h00 -> in_ready=0, out_valid=0, busy=0 throughout.
- Lane 0 path: in_op=8'h00, in_data=8'hA5, out_ready=1 -> out_valid at T+1, out_lane=0, out_data=8'hA5, in_ready high at T+2.
- Overlap priority: in_op=8'h1F -> lane 1, out_valid at T+2. in_op=8'h22 -> lane 2, out_valid at T+3. in_op=8'hC3 -> lane 3, out_valid at T+4.
- Backpressure: lane 3 command, out_ready=0 for 5 cycles then 1 -> out_valid/out_lane/out_data stable for all stall cycles; exactly one transfer; in_ready=0 until after the handshake.
- Unmatched drop: in_op=8'h30 -> err_pulse=1 one cycle, no out_valid, in_ready stays 1. With STMT_LOWERER_SEQ_STATS_EN, err_count goes 0->1; after 3 more drops it reads 4.
- Mid-operation reset: lane 2 accept with HOLD_SCALE=2, rst_n=0 at T+2 -> next cycle out_valid=0, busy=0, state IDLE, no err_pulse; a following lane 0 command issues normally.
